// File: rtl/ysyx_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_ifu : instruction fetch stage
//
// Holds the architectural PC. Issues one word fetch at a time to instruction
// memory. Captures the returned word and presents {inst, pc} to decode.
// Redirects from execute (jal/jalr/taken branch) replace the PC. Any
// in-flight or buffered wrong-path instruction is squashed.
//
// Handshake rule used on every channel: a transfer happens on a rising edge
// where valid && ready are both high. The producer keeps its payload stable
// while valid is high and not yet accepted. The only exception is req_addr,
// which follows a redirect. The response channel has no ready: a rsp_valid
// pulse is taken in S_WAIT and ignored in every other state.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   halt            blocks issue of new fetch requests
//   req_valid/ready fetch request handshake, req_addr = pc
//   rsp_valid/data  single-cycle fetch response pulse and instruction word
//   inst_valid/ready decode handshake, payload {inst, pc}
//   redirect_valid  redirect from execute, target redirect_pc (bits [1:0] dropped)
// ---------------------------------------------------------------------------
module ysyx_ifu #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            halt,

    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,

    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,

    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,

    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q,    pc_d;
    logic [XLEN-1:0] inst_q,  inst_d;
    // drop_q marks the outstanding response as wrong-path: it must be
    // swallowed when it arrives instead of being presented to decode.
    logic            drop_q,  drop_d;

    logic            req_fire;
    logic            inst_fire;
    logic [XLEN-1:0] redirect_target;

    // Instructions are word aligned; the low two target bits are ignored.
    logic            unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};

    // -----------------------------------------------------------------------
    // Outputs. Both valids are qualified by live inputs: halt suppresses a
    // new request, and a redirect hides the buffered instruction in the same
    // cycle so decode can never consume a wrong-path word.
    // -----------------------------------------------------------------------
    assign req_valid  = (state_q == S_REQ) && !halt;
    assign req_addr   = pc_q;
    assign inst_valid = (state_q == S_OUT) && !redirect_valid;
    assign inst       = inst_q;
    assign pc         = pc_q;

    assign req_fire   = req_valid && req_ready;
    assign inst_fire  = inst_valid && inst_ready;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        drop_d  = drop_q;

        case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                    // A request accepted in the redirect cycle still carries
                    // the old pc, so its response is wrong-path.
                    drop_d  = redirect_valid;
                end
            end

            S_WAIT: begin
                if (rsp_valid) begin
                    drop_d = 1'b0;
                    if (drop_q || redirect_valid) begin
                        state_d = S_REQ;
                    end else begin
                        inst_d  = rsp_data;
                        state_d = S_OUT;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end

            S_OUT: begin
                // inst_fire is already false under a redirect, so the
                // buffered word is squashed rather than consumed.
                if (redirect_valid || inst_fire) begin
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_BOOT;
            end
        endcase

        // Redirect wins over the sequential increment.
        if (redirect_valid) begin
            pc_d = redirect_target;
        end else if (inst_fire) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: doc/ysyx_ifu.md
Name: ysyx_ifu

Overview:
Instruction fetch stage, directly upstream of the decode stage. It holds the architectural PC, issues one word fetch at a time to instruction memory over a valid/ready request channel, and captures the returned word. It presents {inst, pc} to decode with a valid/ready handshake, and accepts PC redirects from execute for jal/jalr/taken branches. The block squashes any in-flight or buffered wrong-path instruction.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
XLEN, 32, width of PC, address and instruction.

Ports:
clk  in  1  clock, all state rising-edge.
rst_n  in  1  asynchronous active-low reset.
halt  in  1  when high, no new fetch request is issued (e.g. after ebreak).
req_valid  out  1  fetch request valid.
req_ready  in  1  memory accepts request.
req_addr  out  XLEN  fetch address, equals pc.
rsp_valid  in  1  fetch response valid, single-cycle pulse, never before request accept.
rsp_data  in  XLEN  fetched instruction word.
inst_valid  out  1  instruction available to decode.
inst_ready  in  1  decode consumes instruction.
inst  out  XLEN  instruction to decode.
pc  out  XLEN  address of inst / current fetch PC.
redirect_valid  in  1  control-flow redirect from execute.
redirect_pc  in  XLEN  redirect target.

Behaviour:
- States: S_BOOT, S_REQ, S_WAIT, S_OUT. Reset is asynchronous, active-low, one clock.
- Reset values: state=S_BOOT, pc=RESET_PC, inst=32'h0000_0013 (nop), drop=0. Outputs during reset: req_valid=0, inst_valid=0.
- S_BOOT: unconditionally -> S_REQ on the next edge. The first request is visible in the cycle after reset deassertion plus one edge.
- req_valid = (state==S_REQ) && !halt. req_addr = pc.
- S_REQ: if req_valid && req_ready -> S_WAIT. Otherwise stay; the request is held stable except on redirect.
- S_WAIT: on rsp_valid:
  - drop=1: clear drop, discard the data, -> S_REQ.
  - drop=0: inst<=rsp_data, -> S_OUT.
- inst_valid = (state==S_OUT) && !redirect_valid.
- S_OUT: on inst_valid && inst_ready: pc<=pc+4 (modulo 2^32 wrap, 32'hFFFF_FFFC -> 0), -> S_REQ. Otherwise hold inst and pc stable.
- Only one outstanding request at a time. Fetch-to-decode latency is 2 cycles minimum: accept at edge N, rsp_valid in cycle N+1, inst_valid in cycle N+2.
- Redirect, any state. pc <= {redirect_pc[31:2],2'b00}, where bits [1:0] are always cleared. Redirect has priority over the pc+4 increment.
  - S_REQ, no handshake that cycle: stay in S_REQ with the new pc. req_addr changes; this is the sole permitted change under req_valid.
  - S_REQ, handshake in the same cycle: set drop=1, -> S_WAIT. The old-path response is discarded.
  - S_WAIT, no rsp_valid: set drop=1.
  - S_WAIT, rsp_valid in the same cycle: discard the data, -> S_REQ.
  - S_OUT: the buffered inst is squashed and never handed to decode, even if inst_ready=1. -> S_REQ.
  - S_BOOT: pc loads the target; -> S_REQ as normal.
- halt: only blocks new request issue in S_REQ. An in-flight response is still collected and presented. Deasserting halt resumes fetching from the held pc.
- Reset mid-operation aborts everything immediately. Any response arriving after reset is not expected (memory is reset together).
- No backpressure on the response channel: rsp_valid is always taken in S_WAIT. rsp_valid outside S_WAIT is ignored.

Test Plan:
1. Reset release, req_ready=1, 1-cycle memory returning 32'h0000_0093 -> req_addr=32'h8000_0000; inst_valid asserted 2 cycles after accept with inst=32'h0000_0093, pc=32'h8000_0000. After inst_ready, the next req_addr=32'h8000_0004.
2. inst_ready held 0 for 5 cycles in S_OUT -> inst/pc stable, req_valid=0 throughout. On release, exactly one handshake occurs, then pc=+4.
3. redirect_valid with redirect_pc=32'h8000_0102 while S_WAIT -> the response is dropped with no inst_valid. The next req_addr=32'h8000_0100.
4. redirect in S_OUT with inst_ready=1 in the same cycle -> inst_valid=0 that cycle, no consumption. The next req_addr equals the target.
5. halt=1 after one fetch -> the pending response is still delivered, then req_valid stays 0. Clearing halt issues a request at pc+4.
6. pc=32'hFFFF_FFFC consumed -> next req_addr=32'h0000_0000. Also assert rst_n low mid-S_WAIT -> pc=RESET_PC and inst_valid=0 asynchronously.
